// File: rtl/reg_wr_arbiter_pkg.sv
// Shared types and helpers for the round-robin register write arbiter.
package reg_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

    // Index width that stays at least one bit wide for degenerate counts.
    function automatic int id_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/reg_wr_arbiter_if.sv
// Requester-side handshake bundle: per-requester valid/lock/data and the grant back.
interface reg_arb_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_lock;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;

    modport master (
        output req_valid,
        output req_lock,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_lock,
        input  req_data,
        output req_ready
    );
endinterface

// File: rtl/en_dff.sv
// Parameterized enable flip-flop with synchronous active-low reset.
module en_dff #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] q_q;

    always_comb begin
        q_d = q_q;
        if (en) q_d = d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) q_q <= '0;
        else        q_q <= q_d;
    end

    assign q = q_q;
endmodule

// File: rtl/reg_wr_arbiter_rr_pick.sv
// Rotating priority encoder: first set request at or above ptr, wrapping at NREQ.
module rr_pick
    import reg_arb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [id_w(NREQ)-1:0]   ptr,
    output logic [NREQ-1:0]         gnt,
    output logic [id_w(NREQ)-1:0]   idx,
    output logic                    any
);
    localparam int IDW = id_w(NREQ);

    always_comb begin
        int j;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int k = 0; k < NREQ; k++) begin
            // Explicit wrap so NREQ need not be a power of two.
            j = int'(ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!any && req[j]) begin
                any    = 1'b1;
                idx    = IDW'(j);
                gnt[j] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/reg_wr_arbiter.sv
// Round-robin arbiter sharing one enabled register among NREQ requesters,
// with an optional bounded lock that lets one owner write a short burst.
module reg_wr_arbiter
    import reg_arb_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    reg_arb_if.slave              bus,
    output logic [WIDTH-1:0]      reg_q,
    output logic [id_w(NREQ)-1:0] last_id,
    output logic                  locked
);
    localparam int IDW = id_w(NREQ);
    localparam int BW  = $clog2(MAX_BURST + 1);

    arb_state_t     state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] owner_q, owner_d;
    logic [BW-1:0]  burst_cnt_q, burst_cnt_d;
    logic [IDW-1:0] last_id_q, last_id_d;

    logic [NREQ-1:0]  pick_gnt;
    logic [IDW-1:0]   pick_idx;
    logic             pick_any;
    logic [NREQ-1:0]  ready;
    logic             accept;
    logic [IDW-1:0]   acc_id;
    logic             acc_lock;
    logic [WIDTH-1:0] wr_data;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req (bus.req_valid),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        ready  = '0;
        accept = 1'b0;
        acc_id = '0;
        if (!rst) begin
            if (state_q == IDLE) begin
                ready  = pick_gnt;
                accept = pick_any;
                acc_id = pick_idx;
            end else begin
                accept         = bus.req_valid[owner_q];
                ready[owner_q] = bus.req_valid[owner_q];
                acc_id         = owner_q;
            end
        end
        acc_lock = bus.req_lock[acc_id];
        wr_data  = bus.req_data[int'(acc_id)*WIDTH +: WIDTH];
    end

    assign bus.req_ready = ready;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        burst_cnt_d = burst_cnt_q;
        last_id_d   = last_id_q;
        if (accept) last_id_d = acc_id;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    ptr_d = (acc_id == IDW'(NREQ - 1)) ? '0 : acc_id + IDW'(1);
                    if (acc_lock && (MAX_BURST > 1)) begin
                        state_d     = OWN;
                        owner_d     = acc_id;
                        burst_cnt_d = BW'(1);
                    end
                end
            end
            default: begin
                // ptr already points past the owner, so it is left alone here.
                if (accept && acc_lock && (burst_cnt_q < BW'(MAX_BURST - 1))) begin
                    burst_cnt_d = burst_cnt_q + BW'(1);
                end else begin
                    state_d     = IDLE;
                    burst_cnt_d = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            burst_cnt_q <= '0;
            last_id_q   <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            burst_cnt_q <= burst_cnt_d;
            last_id_q   <= last_id_d;
        end
    end

    en_dff #(.WIDTH(WIDTH)) u_reg (
        .clk   (clk),
        .rst_n (~rst),
        .en    (accept),
        .d     (wr_data),
        .q     (reg_q)
    );

    assign last_id = last_id_q;
    assign locked  = (state_q == OWN);
endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Bench for reg_wr_arbiter: directed scenarios plus random traffic against an ownership-level model.
module tb_reg_wr_arbiter;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MB = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] reg_q;
    logic [1:0]   last_id;
    logic         locked;

    reg_arb_if #(.NREQ(N), .WIDTH(W)) bus ();

    reg_wr_arbiter #(.NREQ(N), .WIDTH(W), .MAX_BURST(MB)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .reg_q   (reg_q),
        .last_id (last_id),
        .locked  (locked)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model: ownership is tracked as "writes made so far in this burst".
    bit         m_known  = 0;
    bit         m_own    = 0;
    int         m_ptr    = 0;
    int         m_owner  = 0;
    int         m_writes = 0;
    int         m_last   = 0;
    logic [7:0] m_reg    = '0;

    function automatic int model_pick();
        if (rst) return -1;
        if (m_own) return bus.req_valid[m_owner] ? m_owner : -1;
        for (int k = 0; k < N; k++) begin
            if (bus.req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_edge(input int g);
        if (rst) begin
            m_known = 1; m_own = 0; m_ptr = 0; m_owner = 0;
            m_writes = 0; m_last = 0; m_reg = '0;
        end else if (g >= 0) begin
            m_reg  = bus.req_data[g*W +: W];
            m_last = g;
            if (!m_own) begin
                m_ptr = (g + 1) % N;
                if (bus.req_lock[g] && MB > 1) begin
                    m_own = 1; m_owner = g; m_writes = 1;
                end
            end else begin
                m_writes++;
                if (!bus.req_lock[g] || m_writes == MB) m_own = 0;
            end
        end else if (m_own) begin
            m_own = 0;
        end
    endtask

    logic [3:0] last_ready;

    task automatic step(input logic r, input logic [3:0] v, input logic [3:0] l, input logic [31:0] d);
        int         g;
        logic [3:0] exp_rdy;
        @(negedge clk);
        rst = r;
        bus.req_valid = v;
        bus.req_lock  = l;
        bus.req_data  = d;
        #1;
        g = model_pick();
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        last_ready = bus.req_ready;
        chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
        if (m_known) begin
            chk("reg_q", 32'(reg_q), 32'(m_reg));
            chk("last_id", 32'(last_id), 32'(m_last));
            chk("locked", 32'(locked), 32'(m_own));
        end
        @(posedge clk);
        model_edge(g);
    endtask

    localparam logic [31:0] DATA4 = 32'h44332211;

    initial begin
        bus.req_valid = '0;
        bus.req_lock  = '0;
        bus.req_data  = '0;

        // Reset with every requester asking.
        step(1, 4'hF, 4'h0, DATA4);
        step(1, 4'hF, 4'h0, DATA4);
        chk("rst_ready", 32'(last_ready), 32'h0);

        // Plain round-robin: grants 0,1,2,3,0.
        for (int i = 0; i < 5; i++) step(0, 4'hF, 4'h0, DATA4);
        step(0, 4'h0, 4'h0, DATA4);
        chk("rr_reg_q_last", 32'(reg_q), 32'h11);

        // Bounded burst from requester 1.
        step(1, 4'h0, 4'h0, DATA4);
        step(0, 4'hF, 4'h0, DATA4);
        for (int i = 0; i < 4; i++) begin
            step(0, 4'hF, 4'h2, DATA4);
            chk("burst_grant1", 32'(last_ready), 32'h2);
        end
        step(0, 4'hF, 4'h2, DATA4);
        chk("burst_then_2", 32'(last_ready), 32'h4);

        // Early release when the owner drops valid.
        step(1, 4'h0, 4'h0, DATA4);
        step(0, 4'h2, 4'h2, DATA4);
        step(0, 4'h5, 4'h0, DATA4);
        chk("release_gap", 32'(last_ready), 32'h0);
        step(0, 4'h5, 4'h0, DATA4);
        chk("release_next2", 32'(last_ready), 32'h4);

        // Reset during requester 3's second locked write.
        step(1, 4'h0, 4'h0, DATA4);
        step(0, 4'h8, 4'h8, DATA4);
        step(1, 4'h8, 4'h8, DATA4);
        step(0, 4'hF, 4'h0, DATA4);
        chk("midrst_grant0", 32'(last_ready), 32'h1);

        // Lone requester 3 with incrementing data exercises ptr wrap.
        for (int i = 0; i < 6; i++) step(0, 4'h8, 4'h0, 32'(8'hA0 + i) << 24);
        step(0, 4'h0, 4'h0, '0);
        chk("wrap_reg_q", 32'(reg_q), 32'hA5);

        // Random traffic with occasional reset.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 49) == 0), 4'($urandom), 4'($urandom), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
